// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and constants for the SPI master controller.
//            - cmd_e   : 2-bit command codes carried in the frame header
//            - state_e : controller FSM states
//            - FRAME_BITS / DATA_BITS : outgoing frame and read-data widths
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        TURN  = 3'd3,
        RECV  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_shifter
// Purpose  : Parallel-load shift register, MSB-first serial out and serial in.
//            The same register carries the outgoing command frame and then
//            collects the incoming read byte in its low bits.
// Ports    : clk, rst_n      - clock, async active-low reset
//            load/load_value - parallel load (wins over shift)
//            shift_en        - shift left by one, serial_in enters at bit 0
//            serial_out      - current MSB
//            rx_value        - low RX_BITS of the register (received data)
// Revision : 1.0 - initial release
// ============================================================================
module spi_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH   = FRAME_BITS,
    parameter int RX_BITS = DATA_BITS
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               shift_en,
    input  logic               serial_in,
    output logic               serial_out,
    output logic [RX_BITS-1:0] rx_value
);

    logic [WIDTH-1:0] r_shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= load_value;
        end else if (shift_en) begin
            r_shreg <= {r_shreg[WIDTH-2:0], serial_in};
        end
    end

    assign serial_out = r_shreg[WIDTH-1];
    assign rx_value   = r_shreg[RX_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : SPI master. Each accepted host request is sent as one ss_n-framed
//            10-bit command {cmd, data} MSB first on mosi; read-data commands
//            then wait TURN_CYCLES and shift 8 bits in from miso, returned on
//            the response port. Single clock domain (no SCLK).
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready/req_cmd/req_data - host request
//            rsp_valid/rsp_data                   - read-data response
//            rsp_err  - only with SPI_MASTER_SEQ_CHECK_EN: read data requested
//                       before any read-address frame completed
//            busy                                 - not IDLE
//            ss_n/mosi/miso                       - SPI pins
// Config   : `define SPI_MASTER_SEQ_CHECK_EN adds rsp_err and its tracking flag.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int TURN_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
`ifdef SPI_MASTER_SEQ_CHECK_EN
    output logic       rsp_err,
`endif
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [3:0] c_bit_last  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_turn_last = 4'(TURN_CYCLES - 1);
    localparam logic [2:0] c_rx_last   = 3'(DATA_BITS - 1);

    state_e                  r_state;
    state_e                  w_next_state;
    cmd_e                    r_cmd;
    logic [3:0]              r_bit_cnt;
    logic [3:0]              r_turn_cnt;
    logic [2:0]              r_rx_cnt;
    logic [7:0]              r_rsp_data;

    logic                    w_accept;
    logic [FRAME_BITS-1:0]   w_load_value;
    logic                    w_shift_en;
    logic                    w_serial_in;
    logic                    w_serial_out;
    logic [DATA_BITS-1:0]    w_rx_value;

    assign w_accept     = req_valid && (r_state == IDLE);
    // Read-data frames carry no payload: zeros go out instead of req_data.
    assign w_load_value = {req_cmd, (req_cmd == CMD_RD_DATA) ? {DATA_BITS{1'b0}} : req_data};
    assign w_shift_en   = (r_state == SHIFT) || (r_state == RECV);
    assign w_serial_in  = (r_state == RECV) ? miso : 1'b0;

    spi_shifter #(
        .WIDTH   (FRAME_BITS),
        .RX_BITS (DATA_BITS)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_accept),
        .load_value (w_load_value),
        .shift_en   (w_shift_en),
        .serial_in  (w_serial_in),
        .serial_out (w_serial_out),
        .rx_value   (w_rx_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are decoded from the state register so that an asynchronous
    // reset drops ss_n and busy immediately, without waiting for an edge.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        ss_n         = 1'b0;
        mosi         = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                ss_n      = 1'b1;
                if (req_valid) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_next_state = SHIFT;
            end
            SHIFT: begin
                mosi = w_serial_out;
                if (r_bit_cnt == c_bit_last) begin
                    w_next_state = (r_cmd == CMD_RD_DATA) ? TURN : DONE;
                end
            end
            TURN: begin
                if (r_turn_cnt == c_turn_last) begin
                    w_next_state = RECV;
                end
            end
            RECV: begin
                if (r_rx_cnt == c_rx_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                ss_n         = 1'b1;
                rsp_valid    = (r_cmd == CMD_RD_DATA);
                w_next_state = IDLE;
            end
            default: begin
                ss_n         = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    // Counters run only inside their own state and return to zero on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_turn_cnt <= '0;
            r_rx_cnt   <= '0;
        end else begin
            r_bit_cnt  <= ((r_state == SHIFT) && (r_bit_cnt  != c_bit_last))  ? r_bit_cnt  + 4'd1 : 4'd0;
            r_turn_cnt <= ((r_state == TURN)  && (r_turn_cnt != c_turn_last)) ? r_turn_cnt + 4'd1 : 4'd0;
            r_rx_cnt   <= ((r_state == RECV)  && (r_rx_cnt   != c_rx_last))   ? r_rx_cnt   + 3'd1 : 3'd0;
        end
    end

    // The response byte is captured on the last receive cycle (including that
    // cycle's miso bit) so it is already on rsp_data when DONE raises rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= CMD_WR_ADDR;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_cmd <= cmd_e'(req_cmd);
            end
            if ((r_state == RECV) && (r_rx_cnt == c_rx_last)) begin
                r_rsp_data <= {w_rx_value[DATA_BITS-2:0], miso};
            end
        end
    end

    assign rsp_data = r_rsp_data;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic r_rd_addr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_set <= 1'b0;
        end else if ((r_state == DONE) && (r_cmd == CMD_RD_ADDR)) begin
            r_rd_addr_set <= 1'b1;
        end
    end

    assign rsp_err = (r_state == DONE) && (r_cmd == CMD_RD_DATA) && !r_rd_addr_set;
`endif

endmodule
`default_nettype wire
